hht_control: RTL and testbench
==============================

# hht_control

Sparse-column dot-product controller for the HHT (Householder transform) datapath. On a start request it walks a column held in memory as (row index, value) word pairs and fetches the matching element of the Householder vector v for each pair. It accumulates value × v[index] and reports the result with a one-cycle done pulse. It sits between the column/vector memories (two combinational read ports) and the HHT update stage.

## Interface
- V_SIZE, 16, number of v elements; valid row indices are 0..V_SIZE-1
- DW, 32, data/address width
- Clk  in  1  clock, all state on rising edge
- Rst  in  1  reset, asynchronous, active-high
- v_values_base  in  DW  word address of v[0] in memory port 2
- wdata_col_base  in  DW  word address of first column word in memory port 1
- addr1  out  DW  read address, column memory (port 1)
- addr2  out  DW  read address, v memory (port 2)
- dataIn1  in  DW  read data for addr1, valid combinationally in the same cycle
- dataIn2  in  DW  read data for addr2, valid combinationally in the same cycle
- csize  in  DW  number of column words (2 per pair)
- RD  in  1  start request, level-sampled in IDLE
- result  out  DW  accumulated dot product
- done  out  1  one-cycle pulse when result is final
- idx_err  out  1  sticky: some index ≥ V_SIZE in the current run

## Operation
- Reset: state IDLE; addr1=0, addr2=0, result=0, done=0, idx_err=0, pair counter=0.
- IDLE: if RD=1, latch wdata_col_base, v_values_base and csize. Clear result and idx_err, then go to FETCH_IDX. If the latched csize<2, go to DONE instead.
- FETCH_IDX (pair k): addr1=col_base+2k. At the clock edge, register dataIn1 as the index. Go to FETCH_VAL.
- FETCH_VAL: addr1=col_base+2k+1, addr2=v_base+index. At the clock edge, result += (dataIn1 × dataIn2)[DW-1:0], wrapping mod 2^DW.
  - If index ≥ V_SIZE: add 0 and set idx_err.
  - Then k++. If 2(k+1) > csize go to DONE, else go to FETCH_IDX.
- DONE: done=1 for this cycle only. Go to IDLE.
- An odd csize leaves the last word unread.
- result and idx_err hold their values until the next start.
- RD is ignored outside IDLE. Dropping RD mid-run does not abort.
- If RD is still 1 on return to IDLE, a new run starts.
- Base address and csize inputs are ignored after latching.
- In IDLE and DONE, addr1 and addr2 hold their last values.

## Timing
- addr1 and addr2 are registered and valid for the whole state cycle. Memory data is sampled at the end of that cycle.
- Latency from the RD-sampling edge to the done pulse: 2·floor(csize/2)+1 cycles. With csize=26 that is 27 cycles.
- Minimum start-to-start period: 2·floor(csize/2)+2 cycles.
- Rst asserted at any point returns everything to reset values immediately; the run in progress is lost.

## Configuration
- HHT_NORM_EN defined: adds output norm_sq (DW bits, reset 0).
  - Cleared on start.
  - In FETCH_VAL, norm_sq += value², mod 2^DW, regardless of idx_err.
  - Final at the done pulse.
- Not defined: the port and its multiplier are absent. All other behaviour is identical.

## Structure
- Package hht_pkg holds:
  - state enum: IDLE, FETCH_IDX, FETCH_VAL, DONE
  - DW default and the V_SIZE default
- Sub-module hht_mac: registered multiply-accumulate with clear and enable.
  - One instance computes result.
  - A second instance computes norm_sq under HHT_NORM_EN.

## Test plan
- Reference run: configure as follows, then assert RD.
  - wdata_col_base=180, csize=26, column words 5,15,6,12,2,15,7,2,4,15,0,1,10,15,8,5,15,0,1,0,2,0,0,5,13,11
  - v_values_base=2, v[0..15]=33,36,35,0,1,98,27,62,98,32,72,21,94,66,26,36
  - Required: done 27 cycles after start, result=4952, idx_err=0; with HHT_NORM_EN, norm_sq=1220.
- Address sequence check, same run: addr1 steps 180,181,…,205; addr2 follows 7,8,4,9,6,2,12,10,17,3,4,2,15, one value per FETCH_VAL.
- csize=0 or 1 -> done 1 cycle after start, result=0, no address change.
- Index 20 with value 3 in a csize=2 run -> result=0, idx_err=1; the next run with valid indices clears idx_err.
- Rst pulsed mid-run (cycle 10 of the reference run) -> all outputs 0 immediately. The RD-restarted run still gives result=4952.
- RD held high continuously -> back-to-back runs every 28 cycles, each with a single-cycle done and identical result.

Source files
------------

// File: rtl/hht_pkg.sv
// Shared definitions for the HHT sparse-column dot-product controller:
// FSM state encoding and default sizes.
package hht_pkg;

  localparam int DW_DEFAULT     = 32;
  localparam int V_SIZE_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FETCH_IDX = 2'd1,
    FETCH_VAL = 2'd2,
    DONE      = 2'd3
  } state_t;

endpackage

// File: rtl/hht_mac.sv
// Registered multiply-accumulate. The product keeps only the low DW bits,
// so the accumulator wraps mod 2^DW. A clear takes priority over enable.
module hht_mac
  import hht_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] acc
);

  logic [DW-1:0] prod;

  assign prod = a * b;

  // Accumulator: cleared on reset or clr, adds a*b when enabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= acc + prod;
  end

endmodule

// File: rtl/hht_control.sv
// Sparse-column dot-product controller. Walks (index, value) word pairs of a
// column in memory port 1, fetches v[index] from memory port 2 and
// accumulates value * v[index]. Out-of-range indices contribute zero and
// set the sticky idx_err flag.
// Optional feature macro: HHT_NORM_EN adds the norm_sq output (sum of value^2).
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for RD; latches bases and csize on start
// FETCH_IDX | addr1 points at the index word of pair k; index registered
// FETCH_VAL | addr1 at value word, addr2 at v[index]; accumulate, k++
// DONE      | one-cycle done pulse, then back to IDLE
module hht_control
  import hht_pkg::*;
#(
  parameter int V_SIZE = V_SIZE_DEFAULT,
  parameter int DW     = DW_DEFAULT
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic [DW-1:0] v_values_base,
  input  logic [DW-1:0] wdata_col_base,
  output logic [DW-1:0] addr1,
  output logic [DW-1:0] addr2,
  input  logic [DW-1:0] dataIn1,
  input  logic [DW-1:0] dataIn2,
  input  logic [DW-1:0] csize,
`ifdef HHT_NORM_EN
  output logic [DW-1:0] norm_sq,
`endif
  input  logic          RD,
  output logic [DW-1:0] result,
  output logic          done,
  output logic          idx_err
);

  state_t        state, state_nxt;
  logic [DW-1:0] col_base;
  logic [DW-1:0] v_base;
  logic [DW-1:0] npairs;
  logic [DW-1:0] k;
  logic [DW-1:0] index;
  logic          start;
  logic          last_pair;
  logic          idx_ok;
  logic          acc_en;
  logic [DW-1:0] v_term;

  assign start     = (state == IDLE) && RD;
  // pair k is the last one when 2(k+2) > csize, i.e. k+1 >= floor(csize/2)
  assign last_pair = ((k + DW'(1)) >= npairs);
  assign idx_ok    = (index < DW'(V_SIZE));
  assign acc_en    = (state == FETCH_VAL);
  assign v_term    = idx_ok ? dataIn2 : '0;

  // State register
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and done pulse
  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (RD) state_nxt = (csize < DW'(2)) ? DONE : FETCH_IDX;
      end
      FETCH_IDX: state_nxt = FETCH_VAL;
      FETCH_VAL: state_nxt = last_pair ? DONE : FETCH_IDX;
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Run parameters, pair counter, registered addresses and error flag
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      col_base <= '0;
      v_base   <= '0;
      npairs   <= '0;
      k        <= '0;
      index    <= '0;
      addr1    <= '0;
      addr2    <= '0;
      idx_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (RD) begin
            col_base <= wdata_col_base;
            v_base   <= v_values_base;
            npairs   <= {1'b0, csize[DW-1:1]};
            k        <= '0;
            idx_err  <= 1'b0;
            // an empty run leaves the addresses untouched
            if (csize >= DW'(2)) addr1 <= wdata_col_base;
          end
        end
        FETCH_IDX: begin
          index <= dataIn1;
          addr1 <= col_base + (k << 1) + DW'(1);
          addr2 <= v_base + dataIn1;
        end
        FETCH_VAL: begin
          if (!idx_ok) idx_err <= 1'b1;
          k <= k + DW'(1);
          if (!last_pair) addr1 <= col_base + ((k + DW'(1)) << 1);
        end
        default: ;
      endcase
    end
  end

  hht_mac #(.DW(DW)) u_mac_dot (
    .clk (Clk),
    .rst (Rst),
    .clr (start),
    .en  (acc_en),
    .a   (dataIn1),
    .b   (v_term),
    .acc (result)
  );

`ifdef HHT_NORM_EN
  hht_mac #(.DW(DW)) u_mac_norm (
    .clk (Clk),
    .rst (Rst),
    .clr (start),
    .en  (acc_en),
    .a   (dataIn1),
    .b   (dataIn1),
    .acc (norm_sq)
  );
`endif

endmodule

// File: tb/tb_hht_control.sv
// Testbench for hht_control: combinational memory models on both ports,
// a driver issuing runs and pushing expected results, and a monitor that
// pops and compares on every done pulse.
module tb_hht_control;
  import hht_pkg::*;

  localparam int DW = 32;

  logic          Clk = 1'b0;
  logic          Rst = 1'b1;
  logic          RD  = 1'b0;
  logic [DW-1:0] v_values_base  = '0;
  logic [DW-1:0] wdata_col_base = '0;
  logic [DW-1:0] csize          = '0;
  logic [DW-1:0] dataIn1, dataIn2, addr1, addr2, result;
  logic          done, idx_err;
`ifdef HHT_NORM_EN
  logic [DW-1:0] norm_sq;
`endif

  logic [DW-1:0] mem1 [256];
  logic [DW-1:0] mem2 [256];

  assign dataIn1 = (addr1 < 256) ? mem1[addr1[7:0]] : '0;
  assign dataIn2 = (addr2 < 256) ? mem2[addr2[7:0]] : '0;

  always #5 Clk = ~Clk;

  hht_control dut (
    .Clk            (Clk),
    .Rst            (Rst),
    .v_values_base  (v_values_base),
    .wdata_col_base (wdata_col_base),
    .addr1          (addr1),
    .addr2          (addr2),
    .dataIn1        (dataIn1),
    .dataIn2        (dataIn2),
    .csize          (csize),
`ifdef HHT_NORM_EN
    .norm_sq        (norm_sq),
`endif
    .RD             (RD),
    .result         (result),
    .done           (done),
    .idx_err        (idx_err)
  );

  typedef struct {
    logic [31:0] res;
    logic        err;
    int          lat;
    logic [31:0] nrm;
    bit          chk_addr;
    logic [31:0] a1;
    logic [31:0] a2;
    time         t0;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  bit   prev_done = 1'b0;

  int ref_col [26] = '{5,15,6,12,2,15,7,2,4,15,0,1,10,15,8,5,15,0,1,0,2,0,0,5,13,11};
  int ref_v   [16] = '{33,36,35,0,1,98,27,62,98,32,72,21,94,66,26,36};
  int exp_a2  [13] = '{7,8,4,9,6,2,12,10,17,3,4,2,15};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] res, input logic err, input int lat,
                              input logic [31:0] nrm, input bit chk,
                              input logic [31:0] a1, input logic [31:0] a2);
    exp_t e;
    e.res = res; e.err = err; e.lat = lat; e.nrm = nrm;
    e.chk_addr = chk; e.a1 = a1; e.a2 = a2; e.t0 = 0;
    return e;
  endfunction

  // Monitor: compare each done pulse against the oldest expected run
  always @(negedge Clk) begin
    if (prev_done) check("done_single", {31'b0, done}, 32'd0);
    prev_done <= (done === 1'b1);
    if (done === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no run pending at %0t", $time);
      end else begin
        mon_e = q.pop_front();
        check("result", result, mon_e.res);
        check("idx_err", {31'b0, idx_err}, {31'b0, mon_e.err});
        check("latency", 32'(int'(($time - mon_e.t0 + 5) / 10)), 32'(mon_e.lat));
`ifdef HHT_NORM_EN
        check("norm_sq", norm_sq, mon_e.nrm);
`endif
        if (mon_e.chk_addr) begin
          check("addr1_hold", addr1, mon_e.a1);
          check("addr2_hold", addr2, mon_e.a2);
        end
      end
    end
  end

  // Issue one run: RD sampled at the posedge after the first negedge.
  // Base/csize inputs are scrambled afterwards to show they were latched.
  task automatic start_run(input logic [31:0] cb, input logic [31:0] vb,
                           input logic [31:0] cs, input exp_t e);
    @(negedge Clk);
    wdata_col_base = cb;
    v_values_base  = vb;
    csize          = cs;
    RD             = 1'b1;
    e.t0           = $time + 5;
    q.push_back(e);
    @(negedge Clk);
    RD             = 1'b0;
    wdata_col_base = 32'hDEAD_0000;
    v_values_base  = 32'h0000_BEEF;
    csize          = 32'd1000;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (q.size() != 0 && n < 400) begin
      @(negedge Clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: got %0d runs pending expected 0", q.size());
      q.delete();
    end
    @(negedge Clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_result"}, result, 32'd0);
    check({tag, "_done"}, {31'b0, done}, 32'd0);
    check({tag, "_idx_err"}, {31'b0, idx_err}, 32'd0);
    check({tag, "_addr1"}, addr1, 32'd0);
    check({tag, "_addr2"}, addr2, 32'd0);
`ifdef HHT_NORM_EN
    check({tag, "_norm_sq"}, norm_sq, 32'd0);
`endif
  endtask

  initial begin
    time t;
    for (int i = 0; i < 256; i++) begin
      mem1[i] = '0;
      mem2[i] = '0;
    end
    for (int i = 0; i < 26; i++) mem1[180 + i] = 32'(ref_col[i]);
    for (int i = 0; i < 16; i++) mem2[2 + i]   = 32'(ref_v[i]);
    mem2[22] = 32'd7;                  // lies beyond v, must not be accumulated
    mem1[100] = 32'd20; mem1[101] = 32'd3;
    mem1[110] = 32'd1;  mem1[111] = 32'd2;
    mem1[112] = 32'd3;  mem1[113] = 32'd4;
    mem1[114] = 32'd99;                // odd trailing word, never read

    repeat (2) @(negedge Clk);
    check_all_zero("reset");
    Rst = 1'b0;

    // Reference run with per-cycle address sequence
    start_run(180, 2, 26, mk(4952, 1'b0, 27, 1220, 1'b1, 205, 15));
    for (int i = 1; i <= 26; i++) begin
      if (i > 1) @(negedge Clk);
      check("addr1_seq", addr1, 32'(180 + i - 1));
      if (i % 2 == 0) check("addr2_seq", addr2, 32'(exp_a2[i / 2 - 1]));
    end
    wait_idle();

    // Out-of-range index contributes nothing and flags idx_err
    start_run(100, 2, 2, mk(0, 1'b1, 3, 9, 1'b1, 101, 22));
    wait_idle();

    // Valid run clears idx_err; odd csize leaves last word unread
    start_run(110, 2, 5, mk(72, 1'b0, 5, 20, 1'b1, 113, 5));
    wait_idle();

    // Empty runs: immediate done, result cleared, addresses untouched
    start_run(50, 9, 0, mk(0, 1'b0, 1, 0, 1'b1, 113, 5));
    wait_idle();
    start_run(60, 9, 1, mk(0, 1'b0, 1, 0, 1'b1, 113, 5));
    wait_idle();

    // Reset mid-run, then RD (still high) restarts the reference run
    @(negedge Clk);
    wdata_col_base = 180; v_values_base = 2; csize = 26; RD = 1'b1;
    repeat (10) @(negedge Clk);
    Rst = 1'b1;
    #1;
    check_all_zero("midrst");
    @(negedge Clk);
    Rst = 1'b0;
    begin
      exp_t e;
      e = mk(4952, 1'b0, 27, 1220, 1'b0, 0, 0);
      e.t0 = $time + 5;
      q.push_back(e);
    end
    @(negedge Clk);
    RD = 1'b0;
    wait_idle();

    // RD held high: three back-to-back runs, 28 cycles apart
    @(negedge Clk);
    wdata_col_base = 180; v_values_base = 2; csize = 26; RD = 1'b1;
    t = $time + 5;
    for (int j = 0; j < 3; j++) begin
      exp_t e;
      e = mk(4952, 1'b0, 27, 1220, 1'b0, 0, 0);
      e.t0 = t + time'(280 * j);
      q.push_back(e);
    end
    repeat (57) @(negedge Clk);
    RD = 1'b0;
    wait_idle();
    repeat (3) @(negedge Clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
